gpr_dump_reader: RTL and testbench

//  Read-side companion to the GPR file: on request, walks a register range through one
//  GPR read port and streams each (index, value) pair out over a valid/ready handshake.

---
 rtl/gpr_dump_reader.sv | 141 ++++++++++++++
 tb/tb_gpr_dump_reader.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dump_reader.sv
// -----------------------------------------------------------------------------
// gpr_dump_reader
//
// Purpose:
//   Walks a contiguous range of GPR indices through one GPR read port and
//   streams every (index, value) pair out over a valid/ready handshake. Used by
//   debug logic and by benches to snapshot architectural register state.
//   The GPR write port is snooped so that a writeback landing on the very edge
//   a register is sampled is still reflected in the dumped value.
//
// Parameters:
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG <= LAST_REG <= 31)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a dump (ignored while busy)
//   abort      cancel a dump in progress (ignored when idle)
//   busy       high from the cycle after an accepted start until done/abort
//   done       one-cycle pulse after the last pair has been accepted
//   rd_sel     GPR read select
//   rd_data    GPR read data, combinational from rd_sel
//   wr_en      snooped GPR write enable
//   wr_sel     snooped GPR write select
//   wr_data    snooped GPR write data
//   out_valid  out_idx/out_data hold a valid pair
//   out_ready  consumer accepts the pair when out_valid & out_ready
//   out_idx    register index of the presented pair
//   out_data   register value of the presented pair
// -----------------------------------------------------------------------------
module gpr_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_sel,
    input  logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [31:0] fetch_value;

    // Value sampled for the register currently being fetched. R0 is hardwired
    // to zero whatever the port returns. A write to the same register on this
    // edge has not reached the array yet, so rd_data would be stale and the
    // snooped write data is forwarded instead.
    always_comb begin
        fetch_value = rd_data;
        if (idx == 5'd0) begin
            fetch_value = 32'd0;
        end else if (wr_en && (wr_sel == idx)) begin
            fetch_value = wr_data;
        end
    end

    // Dump sequencer. IDLE waits for start, FETCH samples one register for a
    // single cycle, SEND holds the pair until the consumer takes it and then
    // either moves on to the next index or finishes with a done pulse. abort
    // outranks everything (including a same-cycle handshake) once a dump is
    // running; in IDLE it is ignored so start always wins there. The dump
    // stops at LAST_REG, so idx never wraps past 31.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 5'd0;
            rd_sel    <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= 5'd0;
            out_data  <= 32'd0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && abort) begin
                state     <= IDLE;
                idx       <= 5'd0;
                rd_sel    <= 5'd0;
                busy      <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx    <= FIRST_IDX;
                            rd_sel <= FIRST_IDX;
                            busy   <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                    FETCH: begin
                        out_idx   <= idx;
                        out_data  <= fetch_value;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (idx == LAST_IDX) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                idx    <= idx + 5'd1;
                                rd_sel <= idx + 5'd1;
                                state  <= FETCH;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpr_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_gpr_dump_reader
//
// Purpose:
//   Bench for gpr_dump_reader. A small GPR array model feeds the read port.
//   Expected pairs are queued when a dump is launched and a separate monitor
//   pops and compares them whenever the DUT completes a handshake. A second
//   instance covers a single-register range.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_gpr_dump_reader;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_pair_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        wr_en   = 1'b0;
    logic [4:0]  wr_sel  = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    logic        s_start;
    logic        s_abort;
    logic        s_busy;
    logic        s_done;
    logic [4:0]  s_rd_sel;
    logic [31:0] s_rd_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [4:0]  s_out_idx;
    logic [31:0] s_out_data;

    logic [31:0] gpr [32];
    exp_pair_t   exp_q[$];
    exp_pair_t   mon_pair;

    logic        inj_armed;
    logic [4:0]  inj_at;
    logic [4:0]  inj_sel;
    logic [31:0] inj_data;

    int          checks_total  = 0;
    int          checks_passed = 0;
    int          cyc;
    int          first_valid;

    gpr_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    gpr_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_single (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .abort     (s_abort),
        .busy      (s_busy),
        .done      (s_done),
        .rd_sel    (s_rd_sel),
        .rd_data   (s_rd_data),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_idx   (s_out_idx),
        .out_data  (s_out_data)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Combinational GPR read ports.
    assign rd_data   = gpr[rd_sel];
    assign s_rd_data = gpr[s_rd_sel];

    // GPR array model: preloaded with 0x1000_0000 + n while in reset, R0
    // writes discarded, writes land on the rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= 32'h1000_0000 + 32'(i);
            end
        end else if (wr_en && (wr_sel != 5'd0)) begin
            gpr[wr_sel] <= wr_data;
        end
    end

    // Write injector: when armed, drives one GPR write during the FETCH cycle
    // of the chosen index (busy, no pair presented, read select on that index).
    always @(negedge clk) begin
        if (inj_armed && busy && !out_valid && (rd_sel == inj_at)) begin
            wr_en   = 1'b1;
            wr_sel  = inj_sel;
            wr_data = inj_data;
        end else begin
            wr_en   = 1'b0;
            wr_sel  = 5'd0;
            wr_data = 32'd0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Monitor: samples just before each rising edge and scores every
    // handshake that will actually complete (abort suppresses it).
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_pair", 32'(out_valid), 32'd0);
            end else begin
                mon_pair = exp_q.pop_front();
                checkOutput("pair_idx", 32'(out_idx), 32'(mon_pair.idx));
                checkOutput("pair_data", out_data, mon_pair.data);
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
    endtask

    // Queue the full 0..31 dump from the current GPR model contents, with an
    // optional override for a register expected to pick up a bypassed write.
    task automatic pushExpected(input int over_idx, input logic [31:0] over_data,
                                input logic use_over);
        exp_pair_t p;
        for (int i = 0; i < 32; i++) begin
            p.idx  = 5'(i);
            p.data = (i == 0) ? 32'd0 : gpr[i];
            if (use_over && (i == over_idx)) begin
                p.data = over_data;
            end
            exp_q.push_back(p);
        end
    endtask

    // Launch a dump and wait (bounded) for done. cycles counts rising edges
    // from the edge that accepted start; an optional 5-cycle stall is applied
    // when the pair at stall_at is first presented.
    task automatic runDump(input int stall_at, input logic [31:0] stall_data,
                           input logic abort_with_start,
                           output int cycles, output int fv);
        int stall_left;
        stall_left = stall_at;
        applyStimulus(1'b1, abort_with_start);
        applyStimulus(1'b0, 1'b0);
        cycles = 0;
        fv     = -1;
        while (!done && cycles < 400) begin
            if (out_valid && fv < 0) begin
                fv = cycles;
            end
            if (stall_left >= 0 && out_valid && (out_idx == 5'(stall_left))) begin
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    cycles++;
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_idx", 32'(out_idx), 32'(stall_left));
                    checkOutput("stall_data", out_data, stall_data);
                    checkOutput("stall_rd_sel", 32'(rd_sel), 32'(stall_left));
                end
                out_ready  = 1'b1;
                stall_left = -1;
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("dump_done", 32'(done), 32'd1);
    endtask

    task automatic waitPair(input int target);
        int n;
        n = 0;
        while (!(out_valid && (out_idx == 5'(target))) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_pair", 32'(out_idx), 32'(target));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        out_ready   = 1'b1;
        s_start     = 1'b0;
        s_abort     = 1'b0;
        s_out_ready = 1'b1;
        inj_armed   = 1'b0;
        inj_at      = 5'd0;
        inj_sel     = 5'd0;
        inj_data    = 32'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_rd_sel", 32'(rd_sel), 32'd0);
        checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;

        // Single-register instance: one pair then done; start held high
        // across FETCH and SEND must not restart the dump.
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        checkOutput("single_busy", 32'(s_busy), 32'd1);
        checkOutput("single_fetch_valid", 32'(s_out_valid), 32'd0);
        checkOutput("single_rd_sel", 32'(s_rd_sel), 32'd5);
        @(negedge clk);
        checkOutput("single_valid", 32'(s_out_valid), 32'd1);
        checkOutput("single_idx", 32'(s_out_idx), 32'd5);
        checkOutput("single_data", s_out_data, 32'h1000_0005);
        @(negedge clk);
        s_start = 1'b0;
        checkOutput("single_done", 32'(s_done), 32'd1);
        checkOutput("single_busy_end", 32'(s_busy), 32'd0);
        @(negedge clk);
        checkOutput("single_done_pulse", 32'(s_done), 32'd0);
        checkOutput("single_idle_valid", 32'(s_out_valid), 32'd0);

        // Full dump with out_ready high: 64 edges, first pair after 1 edge.
        pushExpected(0, 32'd0, 1'b0);
        runDump(-1, 32'd0, 1'b0, cyc, first_valid);
        checkOutput("full_cycles", 32'(cyc), 32'd64);
        checkOutput("first_valid_cycle", 32'(first_valid), 32'd1);
        checkOutput("full_drained", 32'(exp_q.size()), 32'd0);

        // Start during the done pulse is accepted; then abort at pair 10
        // while out_ready is high: no handshake, no done.
        pushExpected(0, 32'd0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("start_on_done", 32'(busy), 32'd1);
        waitPair(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_rd_sel", 32'(rd_sel), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_left", 32'(exp_q.size()), 32'd22);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end

        // Fresh start with a 5-cycle stall at pair 3.
        pushExpected(0, 32'd0, 1'b0);
        runDump(3, 32'h1000_0003, 1'b0, cyc, first_valid);
        checkOutput("stall_cycles", 32'(cyc), 32'd69);
        checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);

        // Write to R7 during the FETCH of 7 is bypassed into pair 7.
        inj_at = 5'd7; inj_sel = 5'd7; inj_data = 32'hDEAD_BEEF; inj_armed = 1'b1;
        pushExpected(7, 32'hDEAD_BEEF, 1'b1);
        runDump(-1, 32'd0, 1'b0, cyc, first_valid);
        inj_armed = 1'b0;
        checkOutput("bypass_drained", 32'(exp_q.size()), 32'd0);

        // Write to R0 during FETCH of 0 still dumps zero.
        inj_at = 5'd0; inj_sel = 5'd0; inj_data = 32'hCAFE_F00D; inj_armed = 1'b1;
        pushExpected(0, 32'd0, 1'b0);
        runDump(-1, 32'd0, 1'b0, cyc, first_valid);
        inj_armed = 1'b0;
        checkOutput("r0_drained", 32'(exp_q.size()), 32'd0);

        // Write to R7 during FETCH of 8 is not seen by pair 7; start and
        // abort together in IDLE start the dump.
        inj_at = 5'd8; inj_sel = 5'd7; inj_data = 32'h1234_5678; inj_armed = 1'b1;
        pushExpected(0, 32'd0, 1'b0);
        runDump(-1, 32'd0, 1'b1, cyc, first_valid);
        inj_armed = 1'b0;
        checkOutput("late_write_cycles", 32'(cyc), 32'd64);
        checkOutput("late_write_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-dump at pair 20.
        pushExpected(0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        waitPair(20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_rd_sel", 32'(rd_sel), 32'd0);
        checkOutput("arst_out_idx", 32'(out_idx), 32'd0);
        checkOutput("arst_out_data", out_data, 32'd0);
        checkOutput("arst_left", 32'(exp_q.size()), 32'd12);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            checkOutput("arst_no_done", 32'(done), 32'd0);
            checkOutput("arst_idle", 32'(busy), 32'd0);
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
